// File: rtl/term_pkg.sv
// Shared geometry, control codes and state encodings for the terminal text plane.
package term_pkg;

  localparam int ROW_W    = 5;
  localparam int COL_W    = 6;
  localparam int LAST_ROW = 16;
  localparam int LAST_COL = 59;

  localparam logic [ROW_W-1:0] LAST_ROW_V = ROW_W'(LAST_ROW);
  localparam logic [COL_W-1:0] LAST_COL_V = COL_W'(LAST_COL);

  // Clear-screen uses the same fill byte as the scroll engine's blank line.
  localparam logic [7:0] FILL_CHAR = 8'h00;

  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_FF = 8'h0C;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SCR_REQ,
    SCR_WAIT,
    CLEAR
  } state_e;

  // Commands understood by the cursor register block.
  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADV,   // advance after a character write, wrapping to the next row
    CUR_CR,    // column to 0
    CUR_LF,    // next row, column unchanged
    CUR_BS,    // one column left
    CUR_HOME   // (0,0)
  } cur_cmd_e;

endpackage

// File: rtl/term_cursor.sv
// Cursor row/column registers. All arithmetic saturates at the last row/column,
// so scrolling is the controller's job, not this block's.
module term_cursor
  import term_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  cur_cmd_e         i_cmd,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  // Next cursor position for the requested command.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    case (i_cmd)
      CUR_ADV: begin
        if (col_q < LAST_COL_V) begin
          col_d = col_q + COL_W'(1);
        end else begin
          col_d = '0;
          if (row_q < LAST_ROW_V) row_d = row_q + ROW_W'(1);
        end
      end
      CUR_CR:   col_d = '0;
      CUR_LF:   if (row_q < LAST_ROW_V) row_d = row_q + ROW_W'(1);
      CUR_BS:   if (col_q != '0) col_d = col_q - COL_W'(1);
      CUR_HOME: begin
        row_d = '0;
        col_d = '0;
      end
      default: ;
    endcase
  end

  // Cursor registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign o_row = row_q;
  assign o_col = col_q;

endmodule

// File: rtl/term_ctrl.sv
// Character-stream controller: decodes UART bytes, writes printable characters
// to VRAM, runs clear-screen, and hands the VRAM port to the scroll engine.
//
// Byte handshake: a byte transfers on a rising edge where i_char_valid and
// o_char_ready are both high; o_char_ready depends only on controller state and
// i_scroll_running, never on i_char_valid. There is no buffering.
module term_ctrl
  import term_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_char_valid,
  input  logic [7:0]             i_char,
  output logic                   o_char_ready,
  output logic                   o_scroll_start,
  input  logic                   i_scroll_running,
  input  logic [ROW_W+COL_W-1:0] i_scr_addr,
  input  logic                   i_scr_w,
  input  logic                   i_scr_ce,
  input  logic [7:0]             i_scr_din,
  output logic [ROW_W+COL_W-1:0] o_vram_addr,
  output logic                   o_vram_w,
  output logic                   o_vram_ce,
  output logic [7:0]             o_vram_din,
  output logic [ROW_W-1:0]       o_cursor_row,
  output logic [COL_W-1:0]       o_cursor_col,
  output logic                   o_busy
);

  state_e           state_q, state_d;
  logic [7:0]       char_q, char_d;
  logic [ROW_W-1:0] clr_row_q, clr_row_d;
  logic [COL_W-1:0] clr_col_q, clr_col_d;
  // Low for the first cycle after reset so ready is low while reset is held.
  logic             alive_q, alive_d;

  cur_cmd_e         cur_cmd;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;

  logic [ROW_W+COL_W-1:0] ctl_addr;
  logic                   ctl_w;
  logic                   ctl_ce;
  logic [7:0]             ctl_din;
  logic                   scr_sel;
  logic                   accept;

  term_cursor u_cursor (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_cmd   (cur_cmd),
    .o_row   (cur_row),
    .o_col   (cur_col)
  );

  assign o_char_ready = alive_q && (state_q == IDLE) && !i_scroll_running;
  assign accept       = i_char_valid && o_char_ready;

  // Next state, cursor command and controller-side VRAM drive.
  always_comb begin
    state_d        = state_q;
    char_d         = char_q;
    clr_row_d      = clr_row_q;
    clr_col_d      = clr_col_q;
    alive_d        = 1'b1;
    cur_cmd        = CUR_NONE;
    ctl_addr       = '0;
    ctl_w          = 1'b0;
    ctl_ce         = 1'b0;
    ctl_din        = '0;
    o_scroll_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (i_char >= 8'h20 && i_char <= 8'h7E) begin
            char_d  = i_char;
            state_d = WRITE;
          end else if (i_char == CC_CR) begin
            cur_cmd = CUR_CR;
          end else if (i_char == CC_LF) begin
            // A newline on the bottom row scrolls instead of moving the cursor.
            if (cur_row == LAST_ROW_V) state_d = SCR_REQ;
            else                       cur_cmd = CUR_LF;
          end else if (i_char == CC_BS) begin
            cur_cmd = CUR_BS;
          end else if (i_char == CC_FF) begin
            state_d = CLEAR;
          end
        end
      end
      WRITE: begin
        ctl_addr = {cur_row, cur_col};
        ctl_din  = char_q;
        ctl_w    = 1'b1;
        ctl_ce   = 1'b1;
        cur_cmd  = CUR_ADV;
        if (cur_col == LAST_COL_V && cur_row == LAST_ROW_V) state_d = SCR_REQ;
        else                                                 state_d = IDLE;
      end
      SCR_REQ: begin
        o_scroll_start = 1'b1;
        if (i_scroll_running) state_d = SCR_WAIT;
      end
      SCR_WAIT: begin
        if (!i_scroll_running) state_d = IDLE;
      end
      CLEAR: begin
        ctl_addr = {clr_row_q, clr_col_q};
        ctl_din  = FILL_CHAR;
        ctl_w    = 1'b1;
        ctl_ce   = 1'b1;
        if (clr_col_q == LAST_COL_V) begin
          clr_col_d = '0;
          if (clr_row_q == LAST_ROW_V) begin
            clr_row_d = '0;
            cur_cmd   = CUR_HOME;
            state_d   = IDLE;
          end else begin
            clr_row_d = clr_row_q + ROW_W'(1);
          end
        end else begin
          clr_col_d = clr_col_q + COL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers; a clear interrupted by reset restarts from scratch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      char_q    <= '0;
      clr_row_q <= '0;
      clr_col_q <= '0;
      alive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      char_q    <= char_d;
      clr_row_q <= clr_row_d;
      clr_col_q <= clr_col_d;
      alive_q   <= alive_d;
    end
  end

  // The scroll engine owns VRAM while a scroll is requested or running; it has
  // no reset of its own, so i_scroll_running alone is enough to hand it the port.
  assign scr_sel = (state_q == SCR_REQ) || (state_q == SCR_WAIT) || i_scroll_running;

  // VRAM port multiplexer.
  always_comb begin
    o_vram_addr = ctl_addr;
    o_vram_w    = ctl_w;
    o_vram_ce   = ctl_ce;
    o_vram_din  = ctl_din;
    if (scr_sel) begin
      o_vram_addr = i_scr_addr;
      o_vram_w    = i_scr_w;
      o_vram_ce   = i_scr_ce;
      o_vram_din  = i_scr_din;
    end
  end

  assign o_cursor_row = cur_row;
  assign o_cursor_col = cur_col;
  assign o_busy       = (state_q != IDLE) || i_scroll_running;

endmodule

// File: tb/tb_term_ctrl.sv
// Directed bench for term_ctrl: character writes, wrap, scroll handshake,
// control codes, clear-screen sweep and reset in the middle of operations.
module tb_term_ctrl;

  logic        clk;
  logic        rst_n;
  logic        char_valid;
  logic [7:0]  char_i;
  logic        char_ready;
  logic        scroll_start;
  logic        scroll_running;
  logic [10:0] scr_addr;
  logic        scr_w;
  logic        scr_ce;
  logic [7:0]  scr_din;
  logic [10:0] vram_addr;
  logic        vram_w;
  logic        vram_ce;
  logic [7:0]  vram_din;
  logic [4:0]  cur_row;
  logic [5:0]  cur_col;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  term_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_char_valid     (char_valid),
    .i_char           (char_i),
    .o_char_ready     (char_ready),
    .o_scroll_start   (scroll_start),
    .i_scroll_running (scroll_running),
    .i_scr_addr       (scr_addr),
    .i_scr_w          (scr_w),
    .i_scr_ce         (scr_ce),
    .i_scr_din        (scr_din),
    .o_vram_addr      (vram_addr),
    .o_vram_w         (vram_w),
    .o_vram_ce        (vram_ce),
    .o_vram_din       (vram_din),
    .o_cursor_row     (cur_row),
    .o_cursor_col     (cur_col),
    .o_busy           (busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: waits (bounded) for ready at a falling edge, presents the byte for
  // one rising edge, returns 1 time unit after that edge (the cycle after accept).
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!char_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!char_ready) begin
      n_checks++;
      $display("FAIL ready_timeout: ready=%b after %0d cycles, need 1", char_ready, t);
    end
    char_valid = 1'b1;
    char_i     = b;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_i     = 8'h00;
  endtask

  // Scroll engine stand-in: acknowledge the request, then finish one cycle later.
  task automatic do_scroll();
    @(negedge clk);
    scroll_running = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    scroll_running = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (char_ready !== 1'b0) $display("FAIL rst_ready: got %b need 0", char_ready); else n_pass++;
    n_checks++;
    if ({vram_w, vram_ce, vram_din} !== 10'h000) $display("FAIL rst_vram: got w=%b ce=%b din=%h need 0", vram_w, vram_ce, vram_din); else n_pass++;
    n_checks++;
    if ({scroll_start, busy} !== 2'b00) $display("FAIL rst_start_busy: got %b%b need 00", scroll_start, busy); else n_pass++;
    n_checks++;
    if ({cur_row, cur_col} !== 11'h000) $display("FAIL rst_cursor: got (%0d,%0d) need (0,0)", cur_row, cur_col); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (char_ready !== 1'b1) $display("FAIL post_rst_ready: got %b need 1", char_ready); else n_pass++;
  endtask

  task automatic test_first_char();
    send_byte(8'h41);
    n_checks++;
    if ({vram_w, vram_ce} !== 2'b11 || vram_addr !== 11'h000 || vram_din !== 8'h41)
      $display("FAIL a_write: got w=%b ce=%b addr=%h din=%h need 1 1 000 41", vram_w, vram_ce, vram_addr, vram_din);
    else n_pass++;
    n_checks++;
    if (char_ready !== 1'b0) $display("FAIL a_ready_during_write: got %b need 0", char_ready); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (char_ready !== 1'b1 || vram_w !== 1'b0) $display("FAIL a_ready_after: got ready=%b w=%b need 1 0", char_ready, vram_w); else n_pass++;
    n_checks++;
    if (cur_row !== 5'd0 || cur_col !== 6'd1) $display("FAIL a_cursor: got (%0d,%0d) need (0,1)", cur_row, cur_col); else n_pass++;
  endtask

  task automatic test_line_wrap();
    send_byte(8'h0D);
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    for (int i = 0; i < 59; i++) send_byte(8'h2E);
    @(posedge clk);
    #1;
    n_checks++;
    if (cur_row !== 5'd3 || cur_col !== 6'd59) $display("FAIL z_cursor_before: got (%0d,%0d) need (3,59)", cur_row, cur_col); else n_pass++;
    send_byte(8'h5A);
    n_checks++;
    if (vram_w !== 1'b1 || vram_addr !== 11'h0FB || vram_din !== 8'h5A)
      $display("FAIL z_write: got w=%b addr=%h din=%h need 1 0fb 5a", vram_w, vram_addr, vram_din);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (cur_row !== 5'd4 || cur_col !== 6'd0) $display("FAIL z_cursor_after: got (%0d,%0d) need (4,0)", cur_row, cur_col); else n_pass++;
    n_checks++;
    if (scroll_start !== 1'b0 || char_ready !== 1'b1) $display("FAIL z_no_scroll: got start=%b ready=%b need 0 1", scroll_start, char_ready); else n_pass++;
  endtask

  task automatic test_bottom_wrap_scroll();
    for (int i = 0; i < 12; i++) send_byte(8'h0A);
    for (int i = 0; i < 59; i++) send_byte(8'h2D);
    send_byte(8'h51);
    n_checks++;
    if (vram_w !== 1'b1 || vram_addr !== 11'h43B || vram_din !== 8'h51)
      $display("FAIL q_write: got w=%b addr=%h din=%h need 1 43b 51", vram_w, vram_addr, vram_din);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (scroll_start !== 1'b1 || char_ready !== 1'b0) $display("FAIL q_start_held: got start=%b ready=%b need 1 0", scroll_start, char_ready); else n_pass++;
    @(negedge clk);
    scroll_running = 1'b1;
    scr_addr = 11'h2AA;
    scr_w    = 1'b1;
    scr_ce   = 1'b1;
    scr_din  = 8'hC3;
    #1;
    n_checks++;
    if (vram_addr !== 11'h2AA || vram_w !== 1'b1 || vram_ce !== 1'b1 || vram_din !== 8'hC3)
      $display("FAIL q_mux_req: got addr=%h w=%b ce=%b din=%h need 2aa 1 1 c3", vram_addr, vram_w, vram_ce, vram_din);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (scroll_start !== 1'b0 || busy !== 1'b1) $display("FAIL q_start_drop: got start=%b busy=%b need 0 1", scroll_start, busy); else n_pass++;
    @(negedge clk);
    scr_addr = 11'h13C;
    scr_w    = 1'b0;
    scr_din  = 8'h5E;
    scroll_running = 1'b0;
    #1;
    n_checks++;
    if (vram_addr !== 11'h13C || vram_w !== 1'b0 || vram_din !== 8'h5E)
      $display("FAIL q_mux_wait: got addr=%h w=%b din=%h need 13c 0 5e", vram_addr, vram_w, vram_din);
    else n_pass++;
    @(posedge clk);
    #1;
    scr_addr = '0;
    scr_ce   = 1'b0;
    scr_din  = '0;
    n_checks++;
    if (char_ready !== 1'b1 || busy !== 1'b0) $display("FAIL q_ready_back: got ready=%b busy=%b need 1 0", char_ready, busy); else n_pass++;
    n_checks++;
    if (cur_row !== 5'd16 || cur_col !== 6'd0) $display("FAIL q_cursor: got (%0d,%0d) need (16,0)", cur_row, cur_col); else n_pass++;
  endtask

  task automatic test_control_codes();
    for (int i = 0; i < 10; i++) send_byte(8'h61);
    send_byte(8'h0A);
    n_checks++;
    if (scroll_start !== 1'b1) $display("FAIL lf_start: got %b need 1", scroll_start); else n_pass++;
    do_scroll();
    n_checks++;
    if (cur_row !== 5'd16 || cur_col !== 6'd10 || char_ready !== 1'b1)
      $display("FAIL lf_cursor: got (%0d,%0d) ready=%b need (16,10) 1", cur_row, cur_col, char_ready);
    else n_pass++;
    send_byte(8'h0D);
    n_checks++;
    if (cur_row !== 5'd16 || cur_col !== 6'd0) $display("FAIL cr_cursor: got (%0d,%0d) need (16,0)", cur_row, cur_col); else n_pass++;
    send_byte(8'h08);
    n_checks++;
    if (cur_row !== 5'd16 || cur_col !== 6'd0) $display("FAIL bs_at_zero: got (%0d,%0d) need (16,0)", cur_row, cur_col); else n_pass++;
    send_byte(8'h78);
    send_byte(8'h78);
    send_byte(8'h08);
    n_checks++;
    if (cur_col !== 6'd1) $display("FAIL bs_step: got col %0d need 1", cur_col); else n_pass++;
    send_byte(8'h01);
    n_checks++;
    if (vram_w !== 1'b0 || cur_col !== 6'd1 || char_ready !== 1'b1)
      $display("FAIL ignored_byte: got w=%b col=%0d ready=%b need 0 1 1", vram_w, cur_col, char_ready);
    else n_pass++;
  endtask

  task automatic test_clear();
    int wr;
    int bad;
    int r;
    int c;
    logic [10:0] exp_a;
    wr = 0; bad = 0; r = 0; c = 0;
    send_byte(8'h0C);
    for (int i = 0; i < 1100; i++) begin
      if (char_ready) break;
      if (vram_w && vram_ce) begin
        exp_a = 11'(r * 64 + c);
        if (vram_addr !== exp_a || vram_din !== 8'h00 || vram_addr[5:0] > 6'd59) begin
          if (bad == 0) $display("FAIL clr_addr: write %0d got addr=%h din=%h need %h 00", wr, vram_addr, vram_din, exp_a);
          bad++;
        end
        wr++;
        c++;
        if (c > 59) begin
          c = 0;
          r++;
        end
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (wr !== 1020) $display("FAIL clr_count: got %0d writes need 1020", wr); else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL clr_seq: got %0d bad writes need 0", bad); else n_pass++;
    n_checks++;
    if (cur_row !== 5'd0 || cur_col !== 6'd0 || char_ready !== 1'b1)
      $display("FAIL clr_done: got (%0d,%0d) ready=%b need (0,0) 1", cur_row, cur_col, char_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    send_byte(8'h41);
    send_byte(8'h0C);
    repeat (100) @(posedge clk);
    #1;
    n_checks++;
    if (vram_w !== 1'b1) $display("FAIL mc_clearing: got w=%b need 1", vram_w); else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({vram_w, vram_ce, vram_din, scroll_start, char_ready} !== 12'h000)
      $display("FAIL mc_rst_out: got w=%b ce=%b din=%h start=%b ready=%b need 0", vram_w, vram_ce, vram_din, scroll_start, char_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (vram_w !== 1'b0 || char_ready !== 1'b1 || cur_col !== 6'd0)
      $display("FAIL mc_abandon: got w=%b ready=%b col=%0d need 0 1 0", vram_w, char_ready, cur_col);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scroll();
    for (int i = 0; i < 17; i++) send_byte(8'h0A);
    n_checks++;
    if (scroll_start !== 1'b1 || cur_row !== 5'd16) $display("FAIL ms_req: got start=%b row=%0d need 1 16", scroll_start, cur_row); else n_pass++;
    @(negedge clk);
    scroll_running = 1'b1;
    scr_addr = 11'h155;
    scr_w    = 1'b0;
    scr_ce   = 1'b1;
    scr_din  = 8'h77;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (scroll_start !== 1'b0 || char_ready !== 1'b0 || cur_row !== 5'd0)
      $display("FAIL ms_rst: got start=%b ready=%b row=%0d need 0 0 0", scroll_start, char_ready, cur_row);
    else n_pass++;
    n_checks++;
    if (vram_addr !== 11'h155 || vram_ce !== 1'b1 || vram_din !== 8'h77)
      $display("FAIL ms_mux: got addr=%h ce=%b din=%h need 155 1 77", vram_addr, vram_ce, vram_din);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (char_ready !== 1'b0 || busy !== 1'b1 || vram_addr !== 11'h155)
      $display("FAIL ms_hold: got ready=%b busy=%b addr=%h need 0 1 155", char_ready, busy, vram_addr);
    else n_pass++;
    scroll_running = 1'b0;
    scr_addr = '0;
    scr_ce   = 1'b0;
    scr_din  = '0;
    #1;
    n_checks++;
    if (char_ready !== 1'b1 || busy !== 1'b0) $display("FAIL ms_release: got ready=%b busy=%b need 1 0", char_ready, busy); else n_pass++;
    send_byte(8'h42);
    n_checks++;
    if (vram_w !== 1'b1 || vram_addr !== 11'h000 || vram_din !== 8'h42)
      $display("FAIL ms_b_write: got w=%b addr=%h din=%h need 1 000 42", vram_w, vram_addr, vram_din);
    else n_pass++;
  endtask

  initial begin
    char_valid     = 1'b0;
    char_i         = 8'h00;
    scroll_running = 1'b0;
    scr_addr       = '0;
    scr_w          = 1'b0;
    scr_ce         = 1'b0;
    scr_din        = '0;
    rst_n          = 1'b0;
    test_reset();
    test_first_char();
    test_line_wrap();
    test_bottom_wrap_scroll();
    test_control_codes();
    test_clear();
    test_reset_mid_clear();
    test_reset_mid_scroll();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
